// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential reverse double-dabble BCD-to-binary converter with a start/ready/done handshake
module bcd_to_bin_seq #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  CLOCK_50,
  input  logic                  RESETN,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BIN_W-1:0]      bin_out
);
  localparam int WW = 4*DIGITS + BIN_W;
  localparam int CW = $clog2(BIN_W + 1);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t state, state_nx;
  logic [WW-1:0] w, w_sh, w_adj;
  logic [CW-1:0] cnt;
  logic bad, last;
  // digits of 8+ after the shift had a ten carried in from above; take back the excess 3
  always_comb begin
    w_sh  = w >> 1;
    w_adj = w_sh;
    bad   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_sh[BIN_W+4*i+3]) w_adj[BIN_W+4*i +: 4] = w_sh[BIN_W+4*i +: 4] - 4'd3;
      if (bcd_in[4*i +: 4] > 4'd9) bad = 1'b1;
    end
  end
  assign last  = cnt == CW'(BIN_W - 1);
  assign ready = state == IDLE;
  assign busy  = state == CONV;
  assign done  = state == DONE;
  always_comb begin
    state_nx = IDLE;
    state_nx = (state == IDLE) ? (start ? (bad ? DONE : CONV) : IDLE) :
               (state == CONV) ? (last ? DONE : CONV) : IDLE;
  end
  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      state   <= IDLE;
      w       <= '0;
      cnt     <= '0;
      err     <= 1'b0;
      bin_out <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        if (bad) begin
          err     <= 1'b1;
          bin_out <= '0;
        end else begin
          w   <= {bcd_in, BIN_W'(0)};
          cnt <= '0;
        end
      end
      if (state == CONV) begin
        w   <= w_adj;
        cnt <= cnt + 1'b1;
        if (last) begin
          bin_out <= w_adj[BIN_W-1:0];
          err     <= 1'b0;
        end
      end
    end
  end
endmodule
